// File: rtl/bus_arbiter_8_6_bit.sv
// Round-robin arbiter sharing one 6-bit internal bus between 8 requesters,
// with a bounded burst length per owner and an 8:1 data mux on the output.

module mux_8_to_1_6_bit (
    input  logic [5:0] d0,
    input  logic [5:0] d1,
    input  logic [5:0] d2,
    input  logic [5:0] d3,
    input  logic [5:0] d4,
    input  logic [5:0] d5,
    input  logic [5:0] d6,
    input  logic [5:0] d7,
    input  logic [2:0] sel,
    output logic [5:0] y
);
    always_comb begin
        y = d0;
        case (sel)
            3'd0: y = d0;
            3'd1: y = d1;
            3'd2: y = d2;
            3'd3: y = d3;
            3'd4: y = d4;
            3'd5: y = d5;
            3'd6: y = d6;
            3'd7: y = d7;
            default: y = d0;
        endcase
    end
endmodule

module bus_arbiter_8_6_bit #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [5:0] d0,
    input  logic [5:0] d1,
    input  logic [5:0] d2,
    input  logic [5:0] d3,
    input  logic [5:0] d4,
    input  logic [5:0] d5,
    input  logic [5:0] d6,
    input  logic [5:0] d7,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       bus_valid,
    output logic [5:0] bus_data
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_next;
    logic [7:0] grant_next;
    logic [2:0] sel_next;
    logic       valid_next;
    logic [3:0] hold_cnt, hold_next;
    logic [2:0] ptr, ptr_next;

    logic [2:0] base;
    logic [2:0] idx;
    logic [2:0] win;
    logic       found;
    logic       release_bus;
    logic [5:0] mux_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= 8'd0;
            sel       <= 3'd0;
            bus_valid <= 1'b0;
            hold_cnt  <= 4'd0;
            ptr       <= 3'd0;
        end else begin
            state     <= state_next;
            grant     <= grant_next;
            sel       <= sel_next;
            bus_valid <= valid_next;
            hold_cnt  <= hold_next;
            ptr       <= ptr_next;
        end
    end

    // On release the scan starts just past the owner, so the owner itself is
    // the last candidate and only wins again if nobody else is asking.
    always_comb begin
        state_next  = state;
        grant_next  = grant;
        sel_next    = sel;
        valid_next  = bus_valid;
        hold_next   = hold_cnt;
        ptr_next    = ptr;
        found       = 1'b0;
        win         = 3'd0;
        idx         = 3'd0;
        base        = (state == GRANT) ? sel + 3'd1 : ptr;
        release_bus = !req[sel] || (hold_cnt == 4'(MAX_HOLD - 1));

        for (int k = 0; k < 8; k++) begin
            idx = base + 3'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    state_next = GRANT;
                    grant_next = 8'd1 << win;
                    sel_next   = win;
                    valid_next = 1'b1;
                    hold_next  = 4'd0;
                end
            end
            GRANT: begin
                if (release_bus) begin
                    ptr_next = sel + 3'd1;
                    if (found) begin
                        grant_next = 8'd1 << win;
                        sel_next   = win;
                        valid_next = 1'b1;
                        hold_next  = 4'd0;
                    end else begin
                        state_next = IDLE;
                        grant_next = 8'd0;
                        valid_next = 1'b0;
                        hold_next  = 4'd0;
                    end
                end else begin
                    hold_next = hold_cnt + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    mux_8_to_1_6_bit u_mux (
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .d4  (d4),
        .d5  (d5),
        .d6  (d6),
        .d7  (d7),
        .sel (sel),
        .y   (mux_y)
    );

    assign bus_data = bus_valid ? mux_y : 6'd0;

endmodule

// File: tb/tb_bus_arbiter_8_6_bit.sv
// Bench for bus_arbiter_8_6_bit: two instances (MAX_HOLD=4 and MAX_HOLD=2) on a
// shared request vector, checked each cycle against an ownership model.

module tb_bus_arbiter_8_6_bit;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [5:0] dv [8];

   logic [7:0] grant_a, grant_b;
   logic [2:0] sel_a, sel_b;
   logic       valid_a, valid_b;
   logic [5:0] data_a, data_b;

   int checks = 0;
   int errors = 0;

   // Model state per instance: owner index (-1 when bus idle), cycles owned,
   // priority pointer and last owner (what sel must keep showing).
   int mOwner [2];
   int mCnt   [2];
   int mPtr   [2];
   int mLast  [2];
   int mHold  [2];

   bus_arbiter_8_6_bit #(.MAX_HOLD(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .req(req),
      .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]),
      .d4(dv[4]), .d5(dv[5]), .d6(dv[6]), .d7(dv[7]),
      .grant(grant_a), .sel(sel_a), .bus_valid(valid_a), .bus_data(data_a)
   );

   bus_arbiter_8_6_bit #(.MAX_HOLD(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req),
      .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]),
      .d4(dv[4]), .d5(dv[5]), .d6(dv[6]), .d7(dv[7]),
      .grant(grant_b), .sel(sel_b), .bus_valid(valid_b), .bus_data(data_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // First requester found walking upward from base, -1 if none.
   function automatic int pick(input int base, input logic [7:0] r);
      for (int k = 0; k < 8; k++) begin
         if (r[(base + k) % 8]) return (base + k) % 8;
      end
      return -1;
   endfunction

   // Ownership rules: a burst ends when the owner lets go or has used up its
   // hold budget; priority then starts just past the old owner.
   task automatic modelStep(input int n, input logic [7:0] r);
      int w;
      if (mOwner[n] < 0) begin
         w = pick(mPtr[n], r);
         if (w >= 0) begin
            mOwner[n] = w;
            mCnt[n]   = 1;
            mLast[n]  = w;
         end
      end else if (!r[mOwner[n]] || mCnt[n] >= mHold[n]) begin
         mPtr[n] = (mOwner[n] + 1) % 8;
         w = pick(mPtr[n], r);
         mOwner[n] = w;
         mCnt[n]   = 1;
         if (w >= 0) mLast[n] = w;
      end else begin
         mCnt[n] = mCnt[n] + 1;
      end
   endtask

   // The model tracks the arbiter's state on the same edges, and an
   // asynchronous reset clears it at once.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < 2; n++) begin
            mOwner[n] = -1;
            mCnt[n]   = 0;
            mPtr[n]   = 0;
            mLast[n]  = 0;
         end
      end else begin
         modelStep(0, req);
         modelStep(1, req);
      end
   end

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [7:0] expGrant(input int n);
      return (mOwner[n] >= 0) ? (8'd1 << mOwner[n]) : 8'd0;
   endfunction

   function automatic logic [5:0] expData(input int n);
      return (mOwner[n] >= 0) ? dv[mOwner[n]] : 6'd0;
   endfunction

   // Per-cycle comparison of both instances against the model, on the
   // falling edge so that registered outputs have settled.
   always @(negedge clk) begin
      checkOutput("a_grant", grant_a, expGrant(0));
      checkOutput("a_sel", {5'd0, sel_a}, 8'(mLast[0]));
      checkOutput("a_valid", {7'd0, valid_a}, {7'd0, mOwner[0] >= 0});
      checkOutput("a_data", {2'd0, data_a}, {2'd0, expData(0)});
      checkOutput("b_grant", grant_b, expGrant(1));
      checkOutput("b_sel", {5'd0, sel_b}, 8'(mLast[1]));
      checkOutput("b_valid", {7'd0, valid_b}, {7'd0, mOwner[1] >= 0});
      checkOutput("b_data", {2'd0, data_b}, {2'd0, expData(1)});
   end

   // Hold req for n rising edges; returns 2 time units after the last edge.
   task automatic applyStimulus(input logic [7:0] r, input int n);
      req = r;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic resetPulse();
      rst_n = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      mHold[0] = 4;
      mHold[1] = 2;
      dv[0] = 6'h11; dv[1] = 6'h05; dv[2] = 6'h2A; dv[3] = 6'h33;
      dv[4] = 6'h0C; dv[5] = 6'h3F; dv[6] = 6'h18; dv[7] = 6'h27;
      req   = 8'h00;
      rst_n = 1'b0;
      #1;
      checkOutput("reset_grant", grant_a, 8'h00);
      checkOutput("reset_valid", {7'd0, valid_a}, 8'h00);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Single requester
      applyStimulus(8'h04, 1);
      checkOutput("single_grant", grant_a, 8'h04);
      checkOutput("single_sel", {5'd0, sel_a}, 8'd2);
      checkOutput("single_data", {2'd0, data_a}, 8'h2A);
      applyStimulus(8'h04, 1);
      applyStimulus(8'h00, 1);
      checkOutput("single_idle", grant_a, 8'h00);
      checkOutput("single_sel_hold", {5'd0, sel_a}, 8'd2);

      // Hold limit and rotation between 1 and 5
      resetPulse();
      applyStimulus(8'h22, 1);
      checkOutput("rot_first", grant_a, 8'h02);
      applyStimulus(8'h22, 3);
      checkOutput("rot_hold4", grant_a, 8'h02);
      applyStimulus(8'h22, 1);
      checkOutput("rot_to5", grant_a, 8'h20);
      applyStimulus(8'h22, 4);
      checkOutput("rot_back1", grant_a, 8'h02);
      applyStimulus(8'h22, 4);
      checkOutput("rot_again5", grant_a, 8'h20);

      // Reset mid-grant, between clock edges
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst_grant", grant_a, 8'h00);
      checkOutput("rst_sel", {5'd0, sel_a}, 8'd0);
      checkOutput("rst_valid", {7'd0, valid_a}, 8'h00);
      checkOutput("rst_data", {2'd0, data_a}, 8'h00);
      req   = 8'h20;
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      checkOutput("rst_regrant", grant_a, 8'h20);
      applyStimulus(8'h00, 1);

      // Wrap-around: grant 6 then go idle leaves priority at 7
      applyStimulus(8'h40, 1);
      applyStimulus(8'h00, 1);
      applyStimulus(8'h81, 1);
      checkOutput("wrap_first7", grant_a, 8'h80);
      applyStimulus(8'h81, 3);
      checkOutput("wrap_hold7", grant_a, 8'h80);
      applyStimulus(8'h81, 1);
      checkOutput("wrap_then0", grant_a, 8'h01);
      applyStimulus(8'h00, 1);

      // Early release of owner 3 while 4 is waiting
      applyStimulus(8'h08, 1);
      checkOutput("early_own3", grant_a, 8'h08);
      applyStimulus(8'h18, 1);
      applyStimulus(8'h10, 1);
      checkOutput("early_to4", grant_a, 8'h10);
      checkOutput("early_data", {2'd0, data_a}, 8'h0C);
      applyStimulus(8'h10, 3);
      checkOutput("early_hold4", grant_a, 8'h10);
      applyStimulus(8'h00, 1);

      // Sole requester is re-granted back-to-back
      applyStimulus(8'h40, 9);
      checkOutput("regrant_b_sel", {5'd0, sel_b}, 8'd6);
      checkOutput("regrant_b_valid", {7'd0, valid_b}, 8'h01);
      checkOutput("regrant_a_grant", grant_a, 8'h40);
      applyStimulus(8'h00, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
